// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if
//   Bundles the three writeback requesters, the register-file write port and
//   the lock/debug status of the register-file write arbiter.
//   Ports (signals):
//     alu_*  : requester 0 (valid/addr/data in, ready out)
//     ld_*   : requester 1 (valid/addr/data in, ready out)
//     dbg_*  : requester 2 (valid/addr/data/lock in, ready out)
//     write_register / write_data / regwrite_ctrl : registered write port
//     locked_o    : lock state active
//     fsm_state_o : raw arbiter state (0 = RR, 1 = LOCKED)
//   Modports: master = requester/register-file side, slave = arbiter.
interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid_i;
  logic [ADDR_W-1:0] alu_addr_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              alu_ready_o;

  logic              ld_valid_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [DATA_W-1:0] ld_data_i;
  logic              ld_ready_o;

  logic              dbg_valid_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_data_i;
  logic              dbg_lock_i;
  logic              dbg_ready_o;

  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] write_data;
  logic              regwrite_ctrl;
  logic              locked_o;
  logic              fsm_state_o;

  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output ld_valid_i, ld_addr_i, ld_data_i,
    output dbg_valid_i, dbg_addr_i, dbg_data_i, dbg_lock_i,
    input  alu_ready_o, ld_ready_o, dbg_ready_o,
    input  write_register, write_data, regwrite_ctrl, locked_o, fsm_state_o
  );

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  ld_valid_i, ld_addr_i, ld_data_i,
    input  dbg_valid_i, dbg_addr_i, dbg_data_i, dbg_lock_i,
    output alu_ready_o, ld_ready_o, dbg_ready_o,
    output write_register, write_data, regwrite_ctrl, locked_o, fsm_state_o
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Round-robin arbiter for the single register-file write port, shared by
//   the ALU writeback (0), load return (1) and debug/host init (2) sources.
//   The granted write is registered and presented one cycle later on
//   write_register / write_data / regwrite_ctrl. The debug source may lock
//   the port for a burst, bounded to LOCK_MAX consecutive locked cycles.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : regfile_wr_arbiter_if.slave (requesters + write port + status)
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Ready is combinational from the current valids and registered state, is
// one-hot or zero, is never high without its valid, and is 0 during reset.
// Requesters hold addr/data stable until ready; data is captured on transfer.
module regfile_wr_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wr_arbiter_if.slave bus
);

  typedef enum logic {
    ST_RR     = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [7:0] LOCK_SAT  = 8'(LOCK_MAX);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [2:0]        req;
  logic [2:0]        grant_vec;
  logic [1:0]        grant_idx;
  logic              grant_any;
  logic [2:0]        cand_sum;
  logic [1:0]        cand;

  assign req = {bus.dbg_valid_i, bus.ld_valid_i, bus.alu_valid_i};

  // Grant selection: first valid requester starting at ptr, wrapping mod 3.
  // In LOCKED only the debug source can be granted.
  always_comb begin
    grant_vec = 3'b000;
    grant_idx = 2'd0;
    grant_any = 1'b0;
    cand_sum  = 3'd0;
    cand      = 2'd0;
    if (rst_n) begin
      if (state_q == ST_LOCKED) begin
        if (req[2]) begin
          grant_vec = 3'b100;
          grant_idx = 2'd2;
          grant_any = 1'b1;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          cand_sum = {1'b0, ptr_q} + 3'(i);
          if (cand_sum >= 3'd3) cand_sum = cand_sum - 3'd3;
          cand = cand_sum[1:0];
          if (!grant_any && req[cand]) begin
            grant_vec[cand] = 1'b1;
            grant_idx       = cand;
            grant_any       = 1'b1;
          end
        end
      end
    end
  end

  // Next state, pointer, lock counter and registered write.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    wr_en_d    = grant_any;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (grant_any) begin
      ptr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      unique case (grant_idx)
        2'd0:    begin wr_addr_d = bus.alu_addr_i; wr_data_d = bus.alu_data_i; end
        2'd1:    begin wr_addr_d = bus.ld_addr_i;  wr_data_d = bus.ld_data_i;  end
        default: begin wr_addr_d = bus.dbg_addr_i; wr_data_d = bus.dbg_data_i; end
      endcase
    end

    unique case (state_q)
      ST_RR: begin
        if (grant_vec[2] && bus.dbg_lock_i) begin
          state_d    = ST_LOCKED;
          lock_cnt_d = 8'd0;
        end
      end
      ST_LOCKED: begin
        lock_cnt_d = (lock_cnt_q == LOCK_SAT) ? lock_cnt_q : lock_cnt_q + 8'd1;
        // Timeout: this last locked cycle may still grant dbg, but the port
        // is released and fairness restarts at requester 0 regardless of
        // dbg_lock_i, so a fresh lock needs a transfer from an RR cycle.
        if (lock_cnt_q == LOCK_LAST) begin
          state_d = ST_RR;
          ptr_d   = 2'd0;
        end else if (grant_vec[2] && !bus.dbg_lock_i) begin
          state_d = ST_RR;
        end
      end
      default: state_d = ST_RR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RR;
      ptr_q      <= 2'd0;
      lock_cnt_q <= 8'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.alu_ready_o    = grant_vec[0];
  assign bus.ld_ready_o     = grant_vec[1];
  assign bus.dbg_ready_o    = grant_vec[2];
  assign bus.write_register = wr_addr_q;
  assign bus.write_data     = wr_data_q;
  assign bus.regwrite_ctrl  = wr_en_q;
  assign bus.locked_o       = (state_q == ST_LOCKED);
  assign bus.fsm_state_o    = state_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter
//   Directed bench for regfile_wr_arbiter. Instance a uses the default
//   LOCK_MAX=16, instance b uses LOCK_MAX=4 for the timeout scenario.
module tb_regfile_wr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.DATA_W(32), .ADDR_W(5)) a ();
  regfile_wr_arbiter_if #(.DATA_W(32), .ADDR_W(5)) b ();

  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .LOCK_MAX(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a)
  );
  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .LOCK_MAX(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  logic [2:0] rdy_a, rdy_b;
  assign rdy_a = {a.dbg_ready_o, a.ld_ready_o, a.alu_ready_o};
  assign rdy_b = {b.dbg_ready_o, b.ld_ready_o, b.alu_ready_o};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    a.alu_valid_i = 0; a.alu_addr_i = '0; a.alu_data_i = '0;
    a.ld_valid_i  = 0; a.ld_addr_i  = '0; a.ld_data_i  = '0;
    a.dbg_valid_i = 0; a.dbg_addr_i = '0; a.dbg_data_i = '0; a.dbg_lock_i = 0;
    b.alu_valid_i = 0; b.alu_addr_i = '0; b.alu_data_i = '0;
    b.ld_valid_i  = 0; b.ld_addr_i  = '0; b.ld_data_i  = '0;
    b.dbg_valid_i = 0; b.dbg_addr_i = '0; b.dbg_data_i = '0; b.dbg_lock_i = 0;
  endtask

  task automatic test_reset;
    idle_all();
    a.alu_valid_i = 1; a.ld_valid_i = 1; a.dbg_valid_i = 1;
    b.alu_valid_i = 1; b.ld_valid_i = 1; b.dbg_valid_i = 1;
    rst_n = 0;
    tick();
    tick();
    checks++; if (rdy_a !== 3'b000) begin failures++; $display("FAIL reset_rdy_a got=%b exp=000", rdy_a); end
    checks++; if (rdy_b !== 3'b000) begin failures++; $display("FAIL reset_rdy_b got=%b exp=000", rdy_b); end
    checks++; if (a.regwrite_ctrl !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", a.regwrite_ctrl); end
    checks++; if (a.write_register !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", a.write_register); end
    checks++; if (a.write_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", a.write_data); end
    checks++; if (a.locked_o !== 1'b0 || b.locked_o !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b%b exp=00", a.locked_o, b.locked_o); end
    idle_all();
    rst_n = 1;
    tick();
    checks++; if (a.regwrite_ctrl !== 1'b0) begin failures++; $display("FAIL reset_idle_we got=%b exp=0", a.regwrite_ctrl); end
  endtask

  task automatic test_round_robin;
    logic [4:0]  ea [3];
    logic [31:0] ed [3];
    logic [2:0]  er;
    int          g;
    ea[0] = 5'd3;  ea[1] = 5'd4;  ea[2] = 5'd5;
    ed[0] = 32'h11; ed[1] = 32'h22; ed[2] = 32'h33;
    a.alu_valid_i = 1; a.alu_addr_i = 5'd3; a.alu_data_i = 32'h11;
    a.ld_valid_i  = 1; a.ld_addr_i  = 5'd4; a.ld_data_i  = 32'h22;
    a.dbg_valid_i = 1; a.dbg_addr_i = 5'd5; a.dbg_data_i = 32'h33; a.dbg_lock_i = 0;
    for (int i = 0; i < 6; i++) begin
      g = i % 3;
      er = 3'b001 << g;
      #1;
      checks++; if (rdy_a !== er) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, rdy_a, er); end
      tick();
      checks++;
      if (a.regwrite_ctrl !== 1'b1 || a.write_register !== ea[g] || a.write_data !== ed[g]) begin
        failures++;
        $display("FAIL rr_write[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, a.regwrite_ctrl, a.write_register, a.write_data, ea[g], ed[g]);
      end
    end
    idle_all();
    tick();
    checks++; if (a.regwrite_ctrl !== 1'b0) begin failures++; $display("FAIL rr_idle_we got=%b exp=0", a.regwrite_ctrl); end
    checks++; if (a.write_register !== 5'd5) begin failures++; $display("FAIL rr_hold_addr got=%0d exp=5", a.write_register); end
  endtask

  task automatic test_single_ld;
    a.ld_valid_i = 1; a.ld_addr_i = 5'd7; a.ld_data_i = 32'hDEADBEEF;
    #1;
    checks++; if (rdy_a !== 3'b010) begin failures++; $display("FAIL ld_ready got=%b exp=010", rdy_a); end
    tick();
    a.ld_valid_i = 0;
    checks++;
    if (a.regwrite_ctrl !== 1'b1 || a.write_register !== 5'd7 || a.write_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL ld_write got=%b/%0d/%h exp=1/7/deadbeef", a.regwrite_ctrl, a.write_register, a.write_data);
    end
    tick();
    checks++; if (a.regwrite_ctrl !== 1'b0) begin failures++; $display("FAIL ld_one_shot got=%b exp=0", a.regwrite_ctrl); end
    checks++; if (a.write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_hold_data got=%h exp=deadbeef", a.write_data); end
  endtask

  task automatic test_dbg_lock;
    // ptr is 2 here (last grant was ld), so dbg wins over the held alu.
    a.alu_valid_i = 1; a.alu_addr_i = 5'd9; a.alu_data_i = 32'h99;
    a.dbg_valid_i = 1; a.dbg_addr_i = 5'd1; a.dbg_data_i = 32'h101; a.dbg_lock_i = 1;
    #1;
    checks++; if (rdy_a !== 3'b100) begin failures++; $display("FAIL lock_first got=%b exp=100", rdy_a); end
    tick();
    checks++; if (a.locked_o !== 1'b1 || a.fsm_state_o !== 1'b1) begin failures++; $display("FAIL lock_enter got=%b/%b exp=1/1", a.locked_o, a.fsm_state_o); end
    checks++; if (a.write_register !== 5'd1 || a.write_data !== 32'h101) begin failures++; $display("FAIL lock_w1 got=%0d/%h exp=1/101", a.write_register, a.write_data); end
    a.dbg_addr_i = 5'd2; a.dbg_data_i = 32'h102;
    #1;
    checks++; if (rdy_a !== 3'b100) begin failures++; $display("FAIL lock_r2 got=%b exp=100", rdy_a); end
    tick();
    checks++; if (a.write_register !== 5'd2 || a.write_data !== 32'h102) begin failures++; $display("FAIL lock_w2 got=%0d/%h exp=2/102", a.write_register, a.write_data); end
    a.dbg_valid_i = 0;
    #1;
    checks++; if (rdy_a !== 3'b000) begin failures++; $display("FAIL lock_gap_rdy got=%b exp=000", rdy_a); end
    tick();
    checks++; if (a.regwrite_ctrl !== 1'b0 || a.locked_o !== 1'b1) begin failures++; $display("FAIL lock_gap got=%b/%b exp=0/1", a.regwrite_ctrl, a.locked_o); end
    a.dbg_valid_i = 1; a.dbg_addr_i = 5'd3; a.dbg_data_i = 32'h103;
    #1;
    checks++; if (rdy_a !== 3'b100) begin failures++; $display("FAIL lock_r3 got=%b exp=100", rdy_a); end
    tick();
    a.dbg_addr_i = 5'd4; a.dbg_data_i = 32'h104; a.dbg_lock_i = 0;
    #1;
    checks++; if (rdy_a !== 3'b100 || a.locked_o !== 1'b1) begin failures++; $display("FAIL lock_r4 got=%b/%b exp=100/1", rdy_a, a.locked_o); end
    tick();
    a.dbg_valid_i = 0;
    checks++; if (a.locked_o !== 1'b0) begin failures++; $display("FAIL lock_exit got=%b exp=0", a.locked_o); end
    checks++; if (a.write_register !== 5'd4 || a.write_data !== 32'h104) begin failures++; $display("FAIL lock_w4 got=%0d/%h exp=4/104", a.write_register, a.write_data); end
    #1;
    checks++; if (rdy_a !== 3'b001) begin failures++; $display("FAIL lock_alu_after got=%b exp=001", rdy_a); end
    tick();
    a.alu_valid_i = 0;
    checks++; if (a.write_register !== 5'd9 || a.write_data !== 32'h99) begin failures++; $display("FAIL lock_alu_w got=%0d/%h exp=9/99", a.write_register, a.write_data); end
  endtask

  task automatic test_lock_timeout;
    b.dbg_valid_i = 1; b.dbg_addr_i = 5'd10; b.dbg_data_i = 32'h200; b.dbg_lock_i = 1;
    #1;
    checks++; if (rdy_b !== 3'b100) begin failures++; $display("FAIL to_enter_rdy got=%b exp=100", rdy_b); end
    tick();
    b.ld_valid_i = 1; b.ld_addr_i = 5'd11; b.ld_data_i = 32'h300;
    for (int j = 0; j < 4; j++) begin
      b.dbg_data_i = 32'h201 + 32'(j);
      #1;
      checks++;
      if (rdy_b !== 3'b100 || b.locked_o !== 1'b1 || b.regwrite_ctrl !== 1'b1) begin
        failures++;
        $display("FAIL to_locked[%0d] got=%b/%b/%b exp=100/1/1", j, rdy_b, b.locked_o, b.regwrite_ctrl);
      end
      tick();
    end
    checks++; if (b.locked_o !== 1'b0) begin failures++; $display("FAIL to_exit got=%b exp=0", b.locked_o); end
    checks++; if (b.write_data !== 32'h204) begin failures++; $display("FAIL to_last_dbg got=%h exp=204", b.write_data); end
    #1;
    checks++; if (rdy_b !== 3'b010) begin failures++; $display("FAIL to_ld_grant got=%b exp=010", rdy_b); end
    tick();
    checks++; if (b.write_register !== 5'd11 || b.write_data !== 32'h300) begin failures++; $display("FAIL to_ld_w got=%0d/%h exp=11/300", b.write_register, b.write_data); end
    #1;
    checks++; if (rdy_b !== 3'b100 || b.locked_o !== 1'b0) begin failures++; $display("FAIL to_rr_dbg got=%b/%b exp=100/0", rdy_b, b.locked_o); end
    tick();
    checks++; if (b.locked_o !== 1'b1) begin failures++; $display("FAIL to_relock got=%b exp=1", b.locked_o); end
    idle_all();
    for (int j = 0; j < 4; j++) tick();
    checks++; if (b.locked_o !== 1'b0) begin failures++; $display("FAIL to_idle_timeout got=%b exp=0", b.locked_o); end
  endtask

  task automatic test_mid_reset;
    // ptr is 1 here (last grant alu), so ld is granted first.
    a.alu_valid_i = 1; a.alu_addr_i = 5'd12; a.alu_data_i = 32'hAA;
    a.ld_valid_i  = 1; a.ld_addr_i  = 5'd13; a.ld_data_i  = 32'hBB;
    #1;
    checks++; if (rdy_a !== 3'b010) begin failures++; $display("FAIL mr_pre got=%b exp=010", rdy_a); end
    tick();
    checks++; if (a.regwrite_ctrl !== 1'b1 || a.write_register !== 5'd13) begin failures++; $display("FAIL mr_inflight got=%b/%0d exp=1/13", a.regwrite_ctrl, a.write_register); end
    rst_n = 0;
    #1;
    checks++; if (rdy_a !== 3'b000) begin failures++; $display("FAIL mr_rdy_in_reset got=%b exp=000", rdy_a); end
    tick();
    checks++;
    if (a.regwrite_ctrl !== 1'b0 || a.write_register !== 5'd0 || a.write_data !== 32'h0) begin
      failures++;
      $display("FAIL mr_cleared got=%b/%0d/%h exp=0/0/0", a.regwrite_ctrl, a.write_register, a.write_data);
    end
    rst_n = 1;
    #1;
    checks++; if (rdy_a !== 3'b001) begin failures++; $display("FAIL mr_alu_first got=%b exp=001", rdy_a); end
    tick();
    checks++; if (a.write_register !== 5'd12 || a.write_data !== 32'hAA) begin failures++; $display("FAIL mr_alu_w got=%0d/%h exp=12/aa", a.write_register, a.write_data); end
    #1;
    checks++; if (rdy_a !== 3'b010) begin failures++; $display("FAIL mr_ld_next got=%b exp=010", rdy_a); end
    tick();
    checks++; if (a.write_register !== 5'd13 || a.write_data !== 32'hBB) begin failures++; $display("FAIL mr_ld_w got=%0d/%h exp=13/bb", a.write_register, a.write_data); end
    idle_all();
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_ld();
    test_dbg_lock();
    test_lock_timeout();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
